mix_layer_seq: RTL and testbench
================================

Name: mix_layer_seq

Overview:
- Sequencer for one mix-layer datapath instance (data-in stage + weight/bias ROMs + MAC logic, driven by run/state, answering with valid).
- Steps the ROM state index 0..N_STEP-1, holds run per step until the datapath reports valid, and issues a write strobe/index so a downstream buffer captures each step's result.
- Upstream start/done handshake, abort, and a per-step watchdog that flags a hung datapath.

Parameters:
- STATE_LEN, `STATE_LEN, width of state index driven to datapath ROMs
- N_STEP, 8, number of state steps per layer pass (1..2**STATE_LEN)
- TIMEOUT, 1024, max cycles run may stay high in one step before error (>=2)
- TO_LEN, 11, watchdog counter width (2**TO_LEN > TIMEOUT)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- abort  in  1  cancel pass; highest priority in any state
- dp_valid  in  1  valid from datapath
- dp_run  out  1  run to datapath
- dp_state  out  STATE_LEN  state index to datapath ROMs
- out_we  out  1  one-cycle strobe: capture datapath result
- out_idx  out  STATE_LEN  step index belonging to out_we
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse, pass completed
- err  out  1  sticky watchdog error, cleared by next accepted start

Behaviour:
- All outputs registered. Reset: state IDLE, dp_run=0, dp_state=0, out_we=0, out_idx=0, busy=0, done=0, err=0, step=0, watchdog=0.
- FSM states: IDLE, LOAD, RUN, STORE, FIN, ERR.
- IDLE: start=1 -> LOAD next cycle, dp_state=0, step=0, err cleared.
- LOAD: one settle cycle for ROM read latency, dp_run=0 -> RUN.
- RUN: dp_run=1; watchdog increments each cycle; watchdog reset to 0 on entry.
  - dp_valid=1 -> STORE.
  - Watchdog reaches TIMEOUT-1 with dp_valid=0 -> ERR.
  - Both in the same cycle: valid wins.
- STORE: dp_run=0, out_we=1, out_idx=step. step==N_STEP-1 -> FIN; otherwise step+1, dp_state=step+1 -> LOAD.
- FIN: done=1 for one cycle, dp_state returns to 0 -> IDLE.
- ERR: dp_run=0, err=1 (sticky) -> IDLE next cycle; no done pulse.
- Timing: start at cycle t -> dp_state=0 at t+1, dp_run=1 at t+2. Valid at v -> out_we at v+1. Next step: run=1 at v+3. Last step: done at v+2, busy=0 at v+3.
- dp_run is guaranteed low for >=2 cycles between steps. This re-arms the datapath's run-edge logic.
- dp_valid outside RUN is ignored.
- start while busy is ignored (no queueing).
- abort=1 in any non-IDLE state: next cycle IDLE, dp_run=0, dp_state=0, out_we=0; no done; err unchanged. abort beats valid and timeout in the same cycle.
- abort together with start in IDLE: stay IDLE.
- Async reset mid-pass: immediate return to reset values; datapath is left unclocked-in (run=0).
- step counter never exceeds N_STEP-1; N_STEP=1 gives exactly one LOAD/RUN/STORE.

Decomposition:
- Shared constants header (the existing consts header): STATE_LEN, N_STEP default per layer, TIMEOUT default, and the FSM state encoding localparams (3-bit, one define per state) so the bench decodes states by name.
- One natural sub-module: mix_layer_wdog. It holds the clear/enable/expired watchdog counter of width TO_LEN. Everything else stays in the top FSM.

Test Plan:
- Reset: rst_n low mid-RUN at step 3 -> all outputs 0 immediately; after release, start -> dp_state=0 at t+1.
- Nominal pass, N_STEP=4, datapath model asserts valid 5 cycles after run rises. Expect:
  - dp_state sequence 0,1,2,3.
  - out_we pulses with out_idx 0,1,2,3.
  - dp_run low >=2 cycles between steps.
  - done one pulse two cycles after the 4th valid.
  - No err.
- Valid in first RUN cycle (zero latency), N_STEP=1 -> run high 1 cycle; out_we at t+3, done at t+4; busy drops t+5.
- Watchdog, TIMEOUT=16, model never asserts valid at step 2:
  - err=1 after 16 run cycles; no done; dp_run=0; back to IDLE.
  - A new start clears err and completes normally.
- Abort at step 1 in RUN, with valid in the same cycle -> no out_we for step 1, no done, IDLE next cycle, dp_state=0.
- Spurious inputs: start pulses while busy and dp_valid pulses during LOAD/STORE -> ignored. Exactly N_STEP out_we and one done per accepted start.

Source files
------------

// File: rtl/mix_layer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mix_layer_seq_pkg
// Description : Shared constants for the mix-layer sequencer: default
//               widths/step counts and the 3-bit FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mix_layer_seq_pkg;

    // Default geometry of one mix layer
    localparam int c_state_len = 3;
    localparam int c_n_step    = 8;
    localparam int c_timeout   = 1024;
    localparam int c_to_len    = 11;

    // FSM state encoding, one constant per state so a bench can decode by name
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_run   = 3'd2;
    localparam logic [2:0] c_st_store = 3'd3;
    localparam logic [2:0] c_st_fin   = 3'd4;
    localparam logic [2:0] c_st_err   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = c_st_idle,
        ST_LOAD  = c_st_load,
        ST_RUN   = c_st_run,
        ST_STORE = c_st_store,
        ST_FIN   = c_st_fin,
        ST_ERR   = c_st_err
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mix_layer_wdog.sv
`default_nettype none
// ============================================================================
// Module      : mix_layer_wdog
// Description : Per-step watchdog counter. Cleared while the datapath is not
//               running, counts run cycles, flags when TIMEOUT-1 is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_layer_wdog
    import mix_layer_seq_pkg::*;
#(
    parameter int TIMEOUT = c_timeout,
    parameter int TO_LEN  = c_to_len
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TO_LEN-1:0] c_limit = TO_LEN'(TIMEOUT - 1);

    logic [TO_LEN-1:0] r_count;

    // Count run cycles; holds at the limit so it can never wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/mix_layer_seq.sv
`default_nettype none
// ============================================================================
// Module      : mix_layer_seq
// Description : Sequencer for one mix-layer datapath. Walks the ROM state
//               index 0..N_STEP-1, holds run until the datapath answers with
//               valid, strobes each result into the output buffer, and guards
//               every step with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_layer_seq
    import mix_layer_seq_pkg::*;
#(
    parameter int STATE_LEN = c_state_len,
    parameter int N_STEP    = c_n_step,
    parameter int TIMEOUT   = c_timeout,
    parameter int TO_LEN    = c_to_len
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 dp_valid,
    output logic                 dp_run,
    output logic [STATE_LEN-1:0] dp_state,
    output logic                 out_we,
    output logic [STATE_LEN-1:0] out_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    // Index of the final step; N_STEP may equal 2**STATE_LEN, so truncate
    localparam logic [STATE_LEN-1:0] c_last = STATE_LEN'(N_STEP - 1);

    seq_state_t           r_state;
    logic                 r_dp_run;
    logic [STATE_LEN-1:0] r_dp_state;
    logic                 r_out_we;
    logic [STATE_LEN-1:0] r_out_idx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [STATE_LEN-1:0] r_step;

    seq_state_t           w_state_nxt;
    logic                 w_dp_run_nxt;
    logic [STATE_LEN-1:0] w_dp_state_nxt;
    logic                 w_out_we_nxt;
    logic [STATE_LEN-1:0] w_out_idx_nxt;
    logic                 w_done_nxt;
    logic                 w_err_nxt;
    logic [STATE_LEN-1:0] w_step_nxt;
    logic                 w_wdog_expired;

    // Watchdog is held clear outside RUN, so it restarts at 0 on each entry
    mix_layer_wdog #(
        .TIMEOUT (TIMEOUT),
        .TO_LEN  (TO_LEN)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state != ST_RUN),
        .i_enable  (r_state == ST_RUN),
        .o_expired (w_wdog_expired)
    );

    // State register plus registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_dp_run   <= 1'b0;
            r_dp_state <= '0;
            r_out_we   <= 1'b0;
            r_out_idx  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_step     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dp_run   <= w_dp_run_nxt;
            r_dp_state <= w_dp_state_nxt;
            r_out_we   <= w_out_we_nxt;
            r_out_idx  <= w_out_idx_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_step     <= w_step_nxt;
        end
    end

    // Next state and next output values; outputs describe the state being entered
    always_comb begin
        w_state_nxt    = r_state;
        w_dp_run_nxt   = 1'b0;
        w_dp_state_nxt = r_dp_state;
        w_out_we_nxt   = 1'b0;
        w_out_idx_nxt  = r_out_idx;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;
        w_step_nxt     = r_step;

        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt    = ST_LOAD;
                    w_dp_state_nxt = '0;
                    w_step_nxt     = '0;
                    w_err_nxt      = 1'b0;
                end
            end
            ST_LOAD: begin
                // One settle cycle for ROM read latency, then raise run
                w_state_nxt  = ST_RUN;
                w_dp_run_nxt = 1'b1;
            end
            ST_RUN: begin
                // Valid wins over a coincident timeout
                if (dp_valid) begin
                    w_state_nxt   = ST_STORE;
                    w_out_we_nxt  = 1'b1;
                    w_out_idx_nxt = r_step;
                end else if (w_wdog_expired) begin
                    w_state_nxt = ST_ERR;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_dp_run_nxt = 1'b1;
                end
            end
            ST_STORE: begin
                if (r_step == c_last) begin
                    w_state_nxt    = ST_FIN;
                    w_done_nxt     = 1'b1;
                    w_dp_state_nxt = '0;
                end else begin
                    w_state_nxt    = ST_LOAD;
                    w_step_nxt     = r_step + 1'b1;
                    w_dp_state_nxt = r_step + 1'b1;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE; the sticky error is kept
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt    = ST_IDLE;
            w_dp_run_nxt   = 1'b0;
            w_dp_state_nxt = '0;
            w_out_we_nxt   = 1'b0;
            w_done_nxt     = 1'b0;
            w_err_nxt      = r_err;
            w_step_nxt     = '0;
        end
    end

    assign dp_run   = r_dp_run;
    assign dp_state = r_dp_state;
    assign out_we   = r_out_we;
    assign out_idx  = r_out_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mix_layer_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mix_layer_seq
// Description : Self-checking bench for mix_layer_seq. A datapath model
//               answers run with valid after a chosen latency; event times
//               are recorded and checked against the cycle relations of the
//               sequencer (start->run +2, valid->we +1, valid->next run +3,
//               valid->done +2, valid->idle +3, 16-cycle watchdog).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_layer_seq;

    localparam int SL = 3;
    localparam int NS = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, dp_valid = 1'b0;
    logic dp_run, out_we, busy, done, err;
    logic [SL-1:0] dp_state, out_idx;
    logic start1 = 1'b0, valid1 = 1'b0;
    logic dp_run1, out_we1, busy1, done1, err1;
    logic [SL-1:0] dp_state1, out_idx1;

    mix_layer_seq #(.STATE_LEN(SL), .N_STEP(NS), .TIMEOUT(TO), .TO_LEN(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dp_valid(dp_valid),
        .dp_run(dp_run), .dp_state(dp_state), .out_we(out_we), .out_idx(out_idx),
        .busy(busy), .done(done), .err(err)
    );

    mix_layer_seq #(.STATE_LEN(SL), .N_STEP(1), .TIMEOUT(TO), .TO_LEN(5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .dp_valid(valid1),
        .dp_run(dp_run1), .dp_state(dp_state1), .out_we(out_we1), .out_idx(out_idx1),
        .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int ncnt = 0;

    // Trace of one pass, in negedge-tick units
    int run_rise[$], st_at_run[$], valid_at[$], we_at[$], we_idx[$], done_at[$];
    int start_at, busy_fall, err_at, err_s1, lat[8];

    task automatic tick();
        @(negedge clk);
        ncnt++;
    endtask

    // Issue one start and play the datapath until busy drops (bounded)
    task automatic run_pass(input bit spur, input int hang_step, input int lat_lo, input int lat_hi);
        bit prev_run = 1'b0, prev_busy = 1'b0, prev_err;
        int rc = 0;
        int k;
        run_rise.delete(); st_at_run.delete(); valid_at.delete();
        we_at.delete(); we_idx.delete(); done_at.delete();
        busy_fall = -1; err_at = -1; err_s1 = -1;
        for (int i = 0; i < 8; i++) lat[i] = $urandom_range(lat_hi, lat_lo);
        tick();
        start = 1'b1; dp_valid = 1'b0; start_at = ncnt; prev_err = err;
        for (int c = 0; c < 400; c++) begin
            tick();
            start = 1'b0; dp_valid = 1'b0;
            if (ncnt == start_at + 1) err_s1 = int'(err);
            if (dp_run && !prev_run) begin
                run_rise.push_back(ncnt); st_at_run.push_back(int'(dp_state)); rc = 0;
            end
            if (out_we) begin we_at.push_back(ncnt); we_idx.push_back(int'(out_idx)); end
            if (done) done_at.push_back(ncnt);
            if (err && !prev_err && err_at < 0) err_at = ncnt;
            if (prev_busy && !busy && busy_fall < 0) busy_fall = ncnt;
            if (dp_run) begin
                rc++;
                k = run_rise.size() - 1;
                if (k != hang_step && rc > lat[k & 7]) begin
                    dp_valid = 1'b1; valid_at.push_back(ncnt);
                end
            end else if (spur && $urandom_range(2, 0) == 0) begin
                dp_valid = 1'b1;
            end
            if (spur && busy && $urandom_range(3, 0) == 0) start = 1'b1;
            prev_run = dp_run; prev_busy = busy; prev_err = err;
            if (busy_fall >= 0) break;
        end
        start = 1'b0; dp_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        int rises = 0, rc = 0, s;
        bit hit = 1'b0;
        outs = {dp_run, dp_state, out_we, out_idx, busy, done, err};
        n_cmp++;
        if (outs !== 11'd0) begin n_fail++; $display("FAIL reset_init: got %b want 0", outs); end
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            tick();
            start = 1'b0; dp_valid = 1'b0;
            if (dp_run) begin if (rc == 0) rises++; rc++; end else rc = 0;
            if (dp_run && rises == 4 && rc == 2) begin
                n_cmp++;
                if (dp_state !== 3'd3) begin n_fail++; $display("FAIL reset_step3: got %0d want 3", dp_state); end
                #1 rst_n = 1'b0;
                #1;
                outs = {dp_run, dp_state, out_we, out_idx, busy, done, err};
                n_cmp++;
                if (outs !== 11'd0) begin n_fail++; $display("FAIL reset_async: got %b want 0", outs); end
                hit = 1'b1;
            end else if (dp_run && rc > 2) begin
                dp_valid = 1'b1;
            end
        end
        n_cmp++;
        if (!hit) begin n_fail++; $display("FAIL reset_reach_step3: got 0 want 1"); end
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1; s = ncnt;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({busy, dp_run, dp_state} !== {1'b1, 1'b0, 3'd0}) begin
            n_fail++; $display("FAIL reset_restart_t1: got busy=%b run=%b st=%0d want 1 0 0", busy, dp_run, dp_state);
        end
        tick();
        n_cmp++;
        if (dp_run !== 1'b1 || ncnt != s + 2) begin n_fail++; $display("FAIL reset_restart_t2: got run=%b want 1", dp_run); end
        // Let the pass finish so the next test starts from IDLE
        for (int c = 0; c < 300 && busy; c++) begin
            tick();
            dp_valid = dp_run;
        end
        dp_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_drain: got busy=%b want 0", busy); end
    endtask

    task automatic test_nominal();
        run_pass(1'b0, -1, 5, 5);
        n_cmp++;
        if (run_rise.size() != NS || we_at.size() != NS || done_at.size() != 1 || valid_at.size() != NS) begin
            n_fail++;
            $display("FAIL nom_counts: got runs=%0d we=%0d done=%0d want %0d %0d 1",
                     run_rise.size(), we_at.size(), done_at.size(), NS, NS);
        end else begin
            n_cmp++;
            if (run_rise[0] != start_at + 2) begin n_fail++; $display("FAIL nom_first_run: got %0d want %0d", run_rise[0], start_at + 2); end
            for (int k = 0; k < NS; k++) begin
                n_cmp++;
                if (st_at_run[k] != k) begin n_fail++; $display("FAIL nom_dp_state: got %0d want %0d", st_at_run[k], k); end
                n_cmp++;
                if (we_at[k] != valid_at[k] + 1 || we_idx[k] != k) begin
                    n_fail++; $display("FAIL nom_we: got t=%0d idx=%0d want t=%0d idx=%0d", we_at[k], we_idx[k], valid_at[k] + 1, k);
                end
                if (k < NS - 1) begin
                    n_cmp++;
                    if (run_rise[k+1] != valid_at[k] + 3) begin
                        n_fail++; $display("FAIL nom_run_gap: got %0d want %0d", run_rise[k+1], valid_at[k] + 3);
                    end
                end
            end
            n_cmp++;
            if (done_at[0] != valid_at[NS-1] + 2) begin n_fail++; $display("FAIL nom_done: got %0d want %0d", done_at[0], valid_at[NS-1] + 2); end
            n_cmp++;
            if (busy_fall != valid_at[NS-1] + 3) begin n_fail++; $display("FAIL nom_busy_fall: got %0d want %0d", busy_fall, valid_at[NS-1] + 3); end
        end
        n_cmp++;
        if (err !== 1'b0 || err_at >= 0 || dp_state !== 3'd0) begin
            n_fail++; $display("FAIL nom_end: got err=%b st=%0d want 0 0", err, dp_state);
        end
    endtask

    task automatic test_zero_latency();
        int s, hi = 0, first = -1, we_t = -1, we_i = -1, dn = -1, fall = -1;
        bit seen = 1'b0;
        tick();
        start1 = 1'b1; s = ncnt;
        for (int c = 0; c < 12; c++) begin
            tick();
            start1 = 1'b0;
            valid1 = dp_run1;
            if (dp_run1) begin hi++; if (first < 0) first = ncnt; end
            if (out_we1 && we_t < 0) begin we_t = ncnt; we_i = int'(out_idx1); end
            if (done1 && dn < 0) dn = ncnt;
            if (busy1) seen = 1'b1; else if (seen && fall < 0) fall = ncnt;
        end
        valid1 = 1'b0;
        n_cmp++;
        if (first != s + 2 || hi != 1) begin n_fail++; $display("FAIL zl_run: got t=%0d n=%0d want t=%0d n=1", first, hi, s + 2); end
        n_cmp++;
        if (we_t != s + 3 || we_i != 0) begin n_fail++; $display("FAIL zl_we: got t=%0d idx=%0d want t=%0d idx=0", we_t, we_i, s + 3); end
        n_cmp++;
        if (dn != s + 4) begin n_fail++; $display("FAIL zl_done: got %0d want %0d", dn, s + 4); end
        n_cmp++;
        if (fall != s + 5) begin n_fail++; $display("FAIL zl_busy_fall: got %0d want %0d", fall, s + 5); end
    endtask

    task automatic test_watchdog();
        run_pass(1'b0, 2, 1, 6);
        n_cmp++;
        if (run_rise.size() != 3 || we_at.size() != 2 || done_at.size() != 0) begin
            n_fail++;
            $display("FAIL wd_counts: got runs=%0d we=%0d done=%0d want 3 2 0", run_rise.size(), we_at.size(), done_at.size());
        end else begin
            n_cmp++;
            if (err_at != run_rise[2] + TO) begin n_fail++; $display("FAIL wd_err_time: got %0d want %0d", err_at, run_rise[2] + TO); end
            n_cmp++;
            if (busy_fall != run_rise[2] + TO + 1) begin n_fail++; $display("FAIL wd_idle: got %0d want %0d", busy_fall, run_rise[2] + TO + 1); end
        end
        n_cmp++;
        if (err !== 1'b1 || dp_run !== 1'b0) begin n_fail++; $display("FAIL wd_sticky: got err=%b run=%b want 1 0", err, dp_run); end
        // A fresh start clears the error and completes normally
        run_pass(1'b0, -1, 0, 4);
        n_cmp++;
        if (err_s1 != 0 || we_at.size() != NS || done_at.size() != 1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_recover: got err_s1=%0d we=%0d done=%0d want 0 %0d 1", err_s1, we_at.size(), done_at.size(), NS);
        end
    endtask

    task automatic test_abort();
        int rises = 0, rc = 0, bad = 0;
        bit hit = 1'b0;
        tick();
        start = 1'b1;
        for (int c = 0; c < 100 && !hit; c++) begin
            tick();
            start = 1'b0; dp_valid = 1'b0;
            if (dp_run) begin if (rc == 0) rises++; rc++; end else rc = 0;
            if (dp_run && rises == 2 && rc == 2) begin
                dp_valid = 1'b1; abort = 1'b1; hit = 1'b1;
            end else if (dp_run && rc > 1) begin
                dp_valid = 1'b1;
            end
        end
        tick();
        abort = 1'b0; dp_valid = 1'b0;
        n_cmp++;
        if (!hit || {out_we, busy, dp_run, dp_state, done, err} !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_next: got we=%b busy=%b run=%b st=%0d done=%b err=%b want all 0",
                     out_we, busy, dp_run, dp_state, done, err);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_we || done || busy) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad); end
        // abort together with start in IDLE keeps the block idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || dp_run !== 1'b0) begin n_fail++; $display("FAIL abort_start_idle: got busy=%b run=%b want 0 0", busy, dp_run); end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 3; p++) begin
            run_pass(1'b1, -1, 0, 9);
            n_cmp++;
            if (we_at.size() != NS || done_at.size() != 1 || valid_at.size() != NS || run_rise.size() != NS) begin
                n_fail++;
                $display("FAIL b2b_counts[%0d]: got we=%0d done=%0d want %0d 1", p, we_at.size(), done_at.size(), NS);
            end else begin
                for (int k = 0; k < NS; k++) begin
                    n_cmp++;
                    if (we_idx[k] != k || we_at[k] != valid_at[k] + 1 || st_at_run[k] != k) begin
                        n_fail++;
                        $display("FAIL b2b_step[%0d]: got idx=%0d t=%0d st=%0d want idx=%0d t=%0d", p, we_idx[k], we_at[k], st_at_run[k], k, valid_at[k] + 1);
                    end
                end
                n_cmp++;
                if (done_at[0] != valid_at[NS-1] + 2 || busy_fall != valid_at[NS-1] + 3) begin
                    n_fail++;
                    $display("FAIL b2b_done[%0d]: got done=%0d fall=%0d want %0d %0d", p, done_at[0], busy_fall, valid_at[NS-1] + 2, valid_at[NS-1] + 3);
                end
            end
        end
    endtask

    initial begin
        tick(); tick(); tick();
        test_reset();
        test_nominal();
        test_zero_latency();
        test_watchdog();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end want end");
        $fatal(1);
    end

endmodule
`default_nettype wire
